// File: rtl/sid_pkg.sv
// Shared SID register-file constants, write-entry type and arbitration grant
// encoding for the write scheduler slice.
package sid_pkg;

  localparam logic [4:0] SID_LAST_WR_IDX = 5'h18;
  localparam logic [4:0] SID_RO_FIRST    = 5'h19;
  localparam logic [4:0] SID_RO_LAST     = 5'h1c;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } sid_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_PLY
  } sid_gnt_e;

  // Anything above the last writable index is read-only or unmapped.
  function automatic logic sid_is_ro(input logic [4:0] addr);
    return addr > SID_LAST_WR_IDX;
  endfunction

endpackage

// File: rtl/sid_write_sched_if.sv
// CPU and player write handshakes into the SID write scheduler.
interface sid_write_sched_if;

  logic       a_valid;
  logic       a_ready;
  logic [4:0] a_addr;
  logic [7:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [4:0] b_addr;
  logic [7:0] b_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/sid_wr_fifo.sv
// Synchronous player-write queue with registered full/empty/count flags.
module sid_wr_fifo
  import sid_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  sid_wr_t                  push_data,
  input  logic                     pop,
  output sid_wr_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  sid_wr_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count_nxt;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (do_pop && !do_push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/sid_write_sched.sv
// Schedules CPU and player register writes onto the SID register file,
// one issue per 1 MHz enable, with a bounded CPU streak over the player queue.
module sid_write_sched
  import sid_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CPU_BURST  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce_1m,
  sid_write_sched_if.slave              bus,
  output logic                          sid_we,
  output logic [4:0]                    sid_addr,
  output logic [7:0]                    sid_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          drop
);

  localparam int unsigned SW = $clog2(CPU_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_BURST);

  logic                         hold_valid;
  sid_wr_t                      hold_q;
  logic                         fifo_full;
  logic                         fifo_empty;
  sid_wr_t                      fifo_head;
  logic [$clog2(FIFO_DEPTH):0]  fifo_cnt;
  logic [SW-1:0]                streak;
  logic                         a_fire;
  logic                         b_fire;
  logic                         a_ro;
  logic                         b_ro;
  sid_gnt_e                     gnt;
  logic                         we_q;
  logic                         drop_q;
  sid_wr_t                      out_q;

  assign bus.a_ready = !hold_valid && !reset;
  assign bus.b_ready = !fifo_full && !reset;
  assign a_fire      = bus.a_valid && bus.a_ready;
  assign b_fire      = bus.b_valid && bus.b_ready;
  assign a_ro        = sid_is_ro(bus.a_addr);
  assign b_ro        = sid_is_ro(bus.b_addr);

  always_comb begin
    gnt = GNT_NONE;
    if (ce_1m) begin
      if (hold_valid && !(streak == STREAK_MAX && !fifo_empty))
        gnt = GNT_CPU;
      else if (!fifo_empty)
        gnt = GNT_PLY;
    end
  end

  sid_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (b_fire && !b_ro),
    .push_data ('{addr: bus.b_addr, data: bus.b_data}),
    .pop       (gnt == GNT_PLY),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_q     <= '0;
      streak     <= '0;
      we_q       <= 1'b0;
      drop_q     <= 1'b0;
      out_q      <= '0;
    end else begin
      drop_q <= (a_fire && a_ro) || (b_fire && b_ro);
      we_q   <= (gnt != GNT_NONE);
      if (gnt == GNT_CPU) begin
        hold_valid <= 1'b0;
        out_q      <= hold_q;
      end else if (gnt == GNT_PLY) begin
        out_q <= fifo_head;
      end
      if (a_fire && !a_ro) begin
        hold_valid <= 1'b1;
        hold_q     <= '{addr: bus.a_addr, data: bus.a_data};
      end
      if (fifo_empty || gnt == GNT_PLY)
        streak <= '0;
      else if (gnt == GNT_CPU)
        streak <= streak + 1'b1;
    end
  end

  // Outputs are forced low while reset is held so a strobe already registered
  // for the cycle reset arrives never reaches the register file.
  assign sid_we     = we_q && !reset;
  assign sid_addr   = reset ? '0 : out_q.addr;
  assign sid_data   = reset ? '0 : out_q.data;
  assign fifo_count = reset ? '0 : fifo_cnt;
  assign drop       = drop_q && !reset;

endmodule

// File: tb/tb_sid_write_sched.sv
// Scoreboard bench for sid_write_sched: directed CPU/player traffic, per-source
// expected queues, and a negedge monitor comparing every sid_we strobe.
module tb_sid_write_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_1m = 1'b0;
  logic       sid_we;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic [3:0] fifo_count;
  logic       drop;

  sid_write_sched_if bus ();

  sid_write_sched #(
    .FIFO_DEPTH (8),
    .CPU_BURST  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce_1m      (ce_1m),
    .bus        (bus),
    .sid_we     (sid_we),
    .sid_addr   (sid_addr),
    .sid_data   (sid_data),
    .fifo_count (fifo_count),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          ce_period = 0;
  int          ce_cnt = 0;
  logic        ce_prev = 1'b0;
  int          issued = 0;
  int          drop_seen = 0;
  int          base;
  int          base_drop;
  logic [12:0] cpu_q [$];
  logic [12:0] ply_q [$];
  int          src_log [$];
  logic [12:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk();
    @(posedge clk);
    #2;
  endtask

  // ce_1m pulse generator: one-cycle pulse every ce_period cycles, 0 disables.
  initial forever begin
    @(posedge clk);
    #1;
    if (ce_period == 0) begin
      ce_1m  = 1'b0;
      ce_cnt = 0;
    end else begin
      ce_cnt++;
      if (ce_cnt >= ce_period) begin
        ce_1m  = 1'b1;
        ce_cnt = 0;
      end else begin
        ce_1m = 1'b0;
      end
    end
  end

  always @(posedge clk) ce_prev <= ce_1m;

  always @(negedge clk) begin
    if (sid_we) begin
      issued++;
      check("we_after_ce", 32'(ce_prev), 1);
      if (sid_data[7]) begin
        src_log.push_back(1);
        if (ply_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ply_we: got %0h:%0h expected none", sid_addr, sid_data);
        end else begin
          mon_exp = ply_q.pop_front();
          check("ply_entry", 32'({sid_addr, sid_data}), 32'(mon_exp));
        end
      end else begin
        src_log.push_back(0);
        if (cpu_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cpu_we: got %0h:%0h expected none", sid_addr, sid_data);
        end else begin
          mon_exp = cpu_q.pop_front();
          check("cpu_entry", 32'({sid_addr, sid_data}), 32'(mon_exp));
        end
      end
    end
    if (drop) drop_seen++;
  end

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    bus.a_valid = 1'b1;
    bus.a_addr  = a;
    bus.a_data  = d;
    while (!bus.a_ready && n < 200) begin
      wait_clk();
      n++;
    end
    if (!bus.a_ready) begin
      checks++;
      failures++;
      $display("FAIL cpu_accept_timeout: got a_ready=0 expected 1 within 200 cycles");
    end else if (a <= 5'h18) begin
      cpu_q.push_back({a, d});
    end
    wait_clk();
    bus.a_valid = 1'b0;
  endtask

  task automatic ply_write(input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    bus.b_valid = 1'b1;
    bus.b_addr  = a;
    bus.b_data  = d;
    while (!bus.b_ready && n < 200) begin
      wait_clk();
      n++;
    end
    if (!bus.b_ready) begin
      checks++;
      failures++;
      $display("FAIL ply_accept_timeout: got b_ready=0 expected 1 within 200 cycles");
    end else if (a <= 5'h18) begin
      ply_q.push_back({a, d});
    end
    wait_clk();
    bus.b_valid = 1'b0;
  endtask

  task automatic wait_issued(input int target, input int bound, input string name);
    int n = 0;
    while (issued < target && n < bound) begin
      wait_clk();
      n++;
    end
    check(name, issued, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.a_valid = 1'b0;
    bus.a_addr  = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_addr  = '0;
    bus.b_data  = '0;
    repeat (3) wait_clk();

    check("rst_sid_we", 32'(sid_we), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_sid_addr", 32'(sid_addr), 0);
    check("rst_sid_data", 32'(sid_data), 0);
    check("rst_a_ready", 32'(bus.a_ready), 0);
    check("rst_b_ready", 32'(bus.b_ready), 0);
    reset = 1'b0;
    #1;
    check("post_rst_a_ready", 32'(bus.a_ready), 1);
    check("post_rst_b_ready", 32'(bus.b_ready), 1);
    wait_clk();

    // Single CPU write with a slow enable.
    ce_period = 32;
    cpu_write(5'h04, 8'h41);
    wait_issued(1, 80, "t35_issue");
    repeat (40) wait_clk();
    check("t35_issue_once", issued, 1);
    ce_period = 0;

    // Read-only indices are dropped, last writable index is issued.
    ce_period = 4;
    base_drop = drop_seen;
    cpu_write(5'h1b, 8'h22);
    check("t38_drop_pulse", 32'(drop), 1);
    check("t38_a_ready", 32'(bus.a_ready), 1);
    check("t38_fifo_count", 32'(fifo_count), 0);
    wait_clk();
    check("t38_drop_single", 32'(drop), 0);
    ply_write(5'h1c, 8'h9c);
    check("t38_ply_drop", 32'(drop), 1);
    check("t38_ply_fifo_count", 32'(fifo_count), 0);
    cpu_write(5'h18, 8'h5a);
    cpu_write(5'h00, 8'h11);
    wait_issued(3, 40, "t38_issue");
    repeat (8) wait_clk();
    check("t38_drop_total", drop_seen - base_drop, 2);
    check("t38_issue_final", issued, 3);
    ce_period = 0;

    // Both sources continuously valid: C, C, P repeating.
    src_log.delete();
    base = issued;
    fork
      begin
        for (int i = 0; i < 8; i++) cpu_write(5'(i), 8'h10 + 8'(i));
      end
      begin
        for (int j = 0; j < 4; j++) ply_write(5'(8 + j), 8'h80 + 8'(j));
      end
    join_none
    repeat (8) wait_clk();
    check("t36_prefill", 32'(fifo_count), 4);
    ce_period = 3;
    wait_issued(base + 12, 100, "t36_issue");
    ce_period = 0;
    check("t36_log_len", src_log.size(), 12);
    for (int k = 0; k < src_log.size() && k < 12; k++)
      check($sformatf("t36_src_%0d", k), src_log[k], (k % 3 == 2) ? 1 : 0);

    // Fill the queue to full with the enable stopped.
    base = issued;
    for (int i = 0; i < 8; i++) ply_write(5'(i), 8'h90 + 8'(i));
    check("t37_count_full", 32'(fifo_count), 8);
    check("t37_b_ready_full", 32'(bus.b_ready), 0);
    fork
      ply_write(5'h08, 8'h98);
    join_none
    repeat (3) wait_clk();
    check("t37_count_held", 32'(fifo_count), 8);
    check("t37_b_ready_held", 32'(bus.b_ready), 0);
    ce_period = 2;
    wait_issued(base + 9, 60, "t37_drain");
    ce_period = 0;
    check("t37_count_empty", 32'(fifo_count), 0);

    // Push and pop in the same cycle, then a long run across pointer wrap.
    base = issued;
    for (int i = 0; i < 3; i++) ply_write(5'(i), 8'hA0 + 8'(i));
    check("t40_count3", 32'(fifo_count), 3);
    ce_period = 1;
    wait_clk();
    ce_period = 0;
    check("t40_b_ready", 32'(bus.b_ready), 1);
    bus.b_valid = 1'b1;
    bus.b_addr  = 5'h03;
    bus.b_data  = 8'hA3;
    ply_q.push_back({5'h03, 8'hA3});
    wait_clk();
    bus.b_valid = 1'b0;
    check("t40_count_push_pop", 32'(fifo_count), 3);
    fork
      begin
        for (int i = 0; i < 20; i++) ply_write(5'(i), 8'hC0 + 8'(i));
      end
    join_none
    ce_period = 2;
    wait_issued(base + 24, 200, "t40_wrap_drain");
    ce_period = 0;
    check("t40_count_end", 32'(fifo_count), 0);

    // Reset in the cycle after an arbitration pulse discards everything.
    base = issued;
    for (int i = 0; i < 4; i++) ply_write(5'(i + 4), 8'hE0 + 8'(i));
    check("t39_count4", 32'(fifo_count), 4);
    ce_period = 1;
    wait_clk();
    ce_period = 0;
    wait_clk();
    reset = 1'b1;
    ply_q.delete();
    cpu_q.delete();
    #1;
    check("t39_rst_we", 32'(sid_we), 0);
    check("t39_rst_count", 32'(fifo_count), 0);
    check("t39_rst_addr", 32'(sid_addr), 0);
    check("t39_rst_data", 32'(sid_data), 0);
    check("t39_rst_a_ready", 32'(bus.a_ready), 0);
    check("t39_rst_b_ready", 32'(bus.b_ready), 0);
    repeat (2) wait_clk();
    reset = 1'b0;
    #1;
    check("t39_a_ready", 32'(bus.a_ready), 1);
    check("t39_b_ready", 32'(bus.b_ready), 1);
    check("t39_count_after", 32'(fifo_count), 0);
    ce_period = 2;
    repeat (10) wait_clk();
    ce_period = 0;
    check("t39_no_we", issued - base, 0);
    check("t39_count_final", 32'(fifo_count), 0);

    check("sb_cpu_left", cpu_q.size(), 0);
    check("sb_ply_left", ply_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
